vecmat_dot_acc: RTL

//  Parametrised, handshaked successor to the fixed 32-lane vector-matrix dot-product unit.
//  - Per beat: multiplies LANES signed fixed-point element pairs (softmax vector x V-matrix column slice).
//  - Reduces the products through a pipelined adder tree.
//  - Accumulates across beats until 'last', so vectors longer than LANES are supported.
//  - Emits one saturated DW-bit result per dot product, with valid/ready flow control.
//  - Sits in the attention datapath between softmax output and the V-projection result buffer.

---
 rtl/vecmat_dot_acc.sv | 136 +++++++++++++
 1 files changed

// File: rtl/vecmat_dot_acc.sv
// vecmat_dot_acc: LANES-wide signed fixed-point dot product with a pipelined adder tree,
// multi-beat accumulation and a saturated, valid/ready-handshaked result.
module vecmat_dot_acc #(
  parameter int LANES    = 32,
  parameter int DW       = 16,
  parameter int FRAC     = 8,
  parameter int ACCW     = 32,
  parameter int TREE_REG = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_last,
  input  logic [LANES*DW-1:0] vector,
  input  logic [LANES*DW-1:0] matrix,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW-1:0]       data_out,
  output logic                out_sat
);
  localparam int LEVELS = $clog2(LANES);
  localparam logic signed [ACCW-1:0] MAX_V = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] MIN_V = ~MAX_V;

  // A held result freezes the whole pipeline, so nothing is ever dropped or reordered.
  logic en;
  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;

  function automatic logic signed [ACCW-1:0] mul_q(input logic signed [DW-1:0] a,
                                                   input logic signed [DW-1:0] b);
    logic signed [2*DW-1:0] full;
    full = (2*DW)'(a) * (2*DW)'(b);
    return ACCW'(full >>> FRAC);
  endfunction

  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int N = LANES >> l;
    logic signed [ACCW-1:0] sum [N];
    logic                   vld;
    logic                   lst;

    if (l == 0) begin : g_prod
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          vld <= 1'b0;
          lst <= 1'b0;
        end else if (en) begin
          vld <= in_valid;
          lst <= in_last;
        end
      end

      // NOTE: data registers carry no reset; only the valid/last tags need a known value.
      always_ff @(posedge clk) begin
        if (en) begin
          for (int i = 0; i < N; i++) sum[i] <= mul_q(vector[i*DW +: DW], matrix[i*DW +: DW]);
        end
      end
    end else if ((l % TREE_REG == 0) || (l == LEVELS)) begin : g_reg
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          vld <= 1'b0;
          lst <= 1'b0;
        end else if (en) begin
          vld <= g_lvl[l-1].vld;
          lst <= g_lvl[l-1].lst;
        end
      end

      always_ff @(posedge clk) begin
        if (en) begin
          for (int j = 0; j < N; j++) sum[j] <= g_lvl[l-1].sum[2*j] + g_lvl[l-1].sum[2*j+1];
        end
      end
    end else begin : g_comb
      assign vld = g_lvl[l-1].vld;
      assign lst = g_lvl[l-1].lst;

      // NOTE: combinational logic uses blocking '=' and writes every element, so no latch.
      always_comb begin
        for (int j = 0; j < N; j++) sum[j] = g_lvl[l-1].sum[2*j] + g_lvl[l-1].sum[2*j+1];
      end
    end
  end

  logic signed [ACCW-1:0] tree_sum;
  logic                   tree_vld;
  logic                   tree_lst;
  assign tree_sum = g_lvl[LEVELS].sum[0];
  assign tree_vld = g_lvl[LEVELS].vld;
  assign tree_lst = g_lvl[LEVELS].lst;

  logic signed [ACCW-1:0] acc;
  logic                   acc_vld;
  logic                   acc_lst;
  logic                   first_beat;

  // first_beat restarts the sum on the beat after a 'last', so there is no gap cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc        <= '0;
      acc_vld    <= 1'b0;
      acc_lst    <= 1'b0;
      first_beat <= 1'b1;
    end else if (en) begin
      acc_vld <= tree_vld;
      acc_lst <= tree_lst;
      if (tree_vld) begin
        acc        <= (first_beat ? '0 : acc) + tree_sum;
        first_beat <= tree_lst;
      end
    end
  end

  logic sat_hi;
  logic sat_lo;
  assign sat_hi = acc > MAX_V;
  assign sat_lo = acc < MIN_V;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      out_sat   <= 1'b0;
    end else if (en && acc_vld && acc_lst) begin
      out_valid <= 1'b1;
      data_out  <= sat_hi ? MAX_V[DW-1:0] : (sat_lo ? MIN_V[DW-1:0] : acc[DW-1:0]);
      out_sat   <= sat_hi || sat_lo;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
